// File: rtl/ft_alu_pkg.sv
// Shared definitions for the fault-tolerant ALU sequencer: op codes, state
// encoding, one-hot ALU control words and the two-rail pair check.
package ft_alu_pkg;

  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_SUB_AB  = 2'd1;
  localparam logic [1:0] OP_SUB_BA  = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam logic [2:0] CTRL_IDLE   = 3'b000;
  localparam logic [2:0] CTRL_ADD    = 3'b001;
  localparam logic [2:0] CTRL_SUB_AB = 3'b010;
  localparam logic [2:0] CTRL_SUB_BA = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A two-rail error pair signals "no error" only when its rails differ.
  function automatic logic pair_valid(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction

  function automatic logic [2:0] op_ctrl(input logic [1:0] op);
    case (op)
      OP_ADD:    return CTRL_ADD;
      OP_SUB_AB: return CTRL_SUB_AB;
      OP_SUB_BA: return CTRL_SUB_BA;
      default:   return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ft_alu_result_check.sv
// Flags a failed check from the captured ALU result channels: either error
// pair not complementary, or the two duplicated result channels disagree.
module ft_alu_result_check
  import ft_alu_pkg::*;
(
  input  logic [2:0] i_x,
  input  logic       i_xc,
  input  logic [1:0] i_xe,
  input  logic [2:0] i_y,
  input  logic       i_yc,
  input  logic [1:0] i_ye,
  output logic       o_fail
);

  logic w_x_pair_bad;
  logic w_y_pair_bad;
  logic w_chan_diff;

  // Pure combinational fail detection.
  always_comb begin
    w_x_pair_bad = ~pair_valid(i_xe);
    w_y_pair_bad = ~pair_valid(i_ye);
    w_chan_diff  = ({i_xc, i_x} != {i_yc, i_y});
    o_fail       = w_x_pair_bad | w_y_pair_bad | w_chan_diff;
  end

endmodule

// File: rtl/ft_alu_sequencer.sv
// Sequences one operation at a time through the duplicated-output ALU:
// drives operands/parity/control, waits to settle, checks, retries, responds.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ALU at idle values, req_ready high, waiting for a request
// ST_DRIVE | ALU inputs held, settle counter running, capture on last cycle
// ST_CHECK | evaluate captured channels; retry, fault out, or succeed
// ST_RESP  | response held on rsp_* until rsp_ready
module ft_alu_sequencer
  import ft_alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [2:0]           req_a,
  input  logic [2:0]           req_b,
  output logic [2:0]           alu_a,
  output logic [2:0]           alu_b,
  output logic                 alu_par,
  output logic [2:0]           alu_c,
  input  logic [2:0]           alu_x,
  input  logic                 alu_xc,
  input  logic [1:0]           alu_xe,
  input  logic [2:0]           alu_y,
  input  logic                 alu_yc,
  input  logic [1:0]           alu_ye,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_result,
  output logic                 rsp_fault,
  output logic                 rsp_illegal,
  output logic [1:0]           rsp_retries,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [3:0]           SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [1:0]           RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE   = 1;

  state_t r_state, w_state_nxt;

  logic [3:0]           r_cnt;
  logic [1:0]           r_retries;
  logic [2:0]           r_alu_a, r_alu_b, r_alu_c;
  logic                 r_alu_par;
  logic [2:0]           r_x, r_y;
  logic                 r_xc, r_yc;
  logic [1:0]           r_xe, r_ye;
  logic                 r_rsp_valid, r_rsp_fault, r_rsp_illegal;
  logic [3:0]           r_rsp_result;
  logic [1:0]           r_rsp_retries;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_fail;
  logic                 w_can_retry;

  ft_alu_result_check u_check (
    .i_x   (r_x),
    .i_xc  (r_xc),
    .i_xe  (r_xe),
    .i_y   (r_y),
    .i_yc  (r_yc),
    .i_ye  (r_ye),
    .o_fail(w_fail)
  );

  assign w_can_retry = (r_retries < RETRY_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_nxt = (req_op == OP_ILLEGAL) ? ST_RESP : ST_DRIVE;
      ST_DRIVE: if (r_cnt == 4'd1) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = (w_fail && w_can_retry) ? ST_DRIVE : ST_RESP;
      ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: ALU drive registers, settle counter, capture, response, error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_retries     <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_c       <= CTRL_IDLE;
      r_alu_par     <= 1'b1;
      r_x           <= '0;
      r_y           <= '0;
      r_xc          <= 1'b0;
      r_yc          <= 1'b0;
      r_xe          <= '0;
      r_ye          <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_fault   <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_retries <= '0;
      r_err_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_op == OP_ILLEGAL) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_illegal <= 1'b1;
              r_rsp_fault   <= 1'b0;
              r_rsp_result  <= '0;
              r_rsp_retries <= '0;
            end else begin
              r_alu_a   <= req_a;
              r_alu_b   <= req_b;
              r_alu_c   <= op_ctrl(req_op);
              r_alu_par <= ~((^req_a) ^ (^req_b));
              r_cnt     <= SETTLE_LD;
              r_retries <= '0;
            end
          end
        end
        ST_DRIVE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_x  <= alu_x;
            r_xc <= alu_xc;
            r_xe <= alu_xe;
            r_y  <= alu_y;
            r_yc <= alu_yc;
            r_ye <= alu_ye;
          end
        end
        ST_CHECK: begin
          if (w_fail && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_ONE;
          if (w_fail && w_can_retry) begin
            r_retries <= r_retries + 2'd1;
            r_cnt     <= SETTLE_LD;
          end else begin
            r_rsp_valid   <= 1'b1;
            r_rsp_illegal <= 1'b0;
            r_rsp_fault   <= w_fail;
            r_rsp_result  <= {r_xc, r_x};
            r_rsp_retries <= r_retries;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_c     <= CTRL_IDLE;
            r_alu_par   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_c       = r_alu_c;
  assign alu_par     = r_alu_par;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_fault   = r_rsp_fault;
  assign rsp_illegal = r_rsp_illegal;
  assign rsp_retries = r_rsp_retries;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_ft_alu_sequencer.sv
// Directed bench for ft_alu_sequencer with a behavioural fault-tolerant ALU
// model that can corrupt the error pair once or break channel agreement.
module tb_ft_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0] req_op;
  logic [2:0] req_a, req_b, alu_a, alu_b, alu_c;
  logic       alu_par;
  logic [2:0] alu_x, alu_y;
  logic       alu_xc, alu_yc;
  logic [1:0] alu_xe, alu_ye;
  logic [3:0] rsp_result;
  logic       rsp_fault, rsp_illegal;
  logic [1:0] rsp_retries;
  logic [3:0] err_cnt;

  always #5 clk = ~clk;

  ft_alu_sequencer #(.SETTLE_CYCLES(1), .MAX_RETRY(2), .ERR_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_par(alu_par), .alu_c(alu_c),
    .alu_x(alu_x), .alu_xc(alu_xc), .alu_xe(alu_xe),
    .alu_y(alu_y), .alu_yc(alu_yc), .alu_ye(alu_ye),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_fault(rsp_fault), .rsp_illegal(rsp_illegal),
    .rsp_retries(rsp_retries), .err_cnt(err_cnt)
  );

  // ALU model: parity-checked codeword, duplicated outputs, injectable faults.
  logic       xe_once, y_bad;
  int         drive_cyc;
  logic [3:0] m_sum;
  logic [2:0] m_na, m_nb;
  logic       m_p;

  always @(posedge clk) drive_cyc <= (alu_c == 3'b000) ? 0 : drive_cyc + 1;

  always_comb begin
    m_na  = ~alu_a + 3'd1;
    m_nb  = ~alu_b + 3'd1;
    m_sum = 4'd0;
    case (alu_c)
      3'b001:  m_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b010:  m_sum = {1'b0, alu_a} + {1'b0, m_nb};
      3'b100:  m_sum = {1'b0, m_na} + {1'b0, alu_b};
      default: m_sum = 4'd0;
    endcase
    m_p    = (^alu_a) ^ (^alu_b) ^ alu_par;
    alu_x  = m_sum[2:0];
    alu_xc = m_sum[3];
    alu_y  = y_bad ? (m_sum[2:0] ^ 3'b001) : m_sum[2:0];
    alu_yc = m_sum[3];
    alu_xe = (xe_once && drive_cyc == 0) ? 2'b11 : {m_p, ~m_p};
    alu_ye = {m_p, ~m_p};
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [2:0] s_a, s_b, s_c;
  logic       s_par;
  int         s_lat;

  // Issue a request at a negedge; sample ALU drive one cycle later; wait for response.
  task automatic run_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    chk("req_ready_before_accept", {31'd0, req_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    s_a = alu_a; s_b = alu_b; s_c = alu_c; s_par = alu_par;
    s_lat = 1;
    while (!rsp_valid && s_lat < 40) begin
      @(negedge clk);
      s_lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {31'd0, rsp_valid}, 0);
    chk("alu_c_idle_after_ack", {29'd0, alu_c}, 0);
    chk("req_ready_after_ack", {31'd0, req_ready}, 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] a, b, c;
    logic       par;
    logic [3:0] res;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vt[9];
  int   exp_err;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'd0, 3'd3, 3'd2, 3'b001, 1'b0, 4'b0101, 1'b0, 3};
    vt[1] = '{2'd1, 3'd3, 3'd2, 3'b010, 1'b0, 4'b1001, 1'b0, 3};
    vt[2] = '{2'd2, 3'd3, 3'd5, 3'b100, 1'b1, 4'b1010, 1'b0, 3};
    vt[3] = '{2'd0, 3'd7, 3'd7, 3'b001, 1'b1, 4'b1110, 1'b0, 3};
    vt[4] = '{2'd0, 3'd0, 3'd0, 3'b001, 1'b1, 4'b0000, 1'b0, 3};
    vt[5] = '{2'd1, 3'd5, 3'd5, 3'b010, 1'b1, 4'b1000, 1'b0, 3};
    vt[6] = '{2'd2, 3'd1, 3'd6, 3'b100, 1'b0, 4'b1101, 1'b0, 3};
    vt[7] = '{2'd0, 3'd4, 3'd1, 3'b001, 1'b1, 4'b0101, 1'b0, 3};
    vt[8] = '{2'd3, 3'd5, 3'd2, 3'b000, 1'b1, 4'b0000, 1'b1, 1};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 2'd0; req_a = 3'd0; req_b = 3'd0;
    xe_once = 1'b0; y_bad = 1'b0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_alu_c", {29'd0, alu_c}, 0);
    chk("rst_alu_par", {31'd0, alu_par}, 1);
    chk("rst_alu_ab", {26'd0, alu_a, alu_b}, 0);
    chk("rst_err_cnt", {28'd0, err_cnt}, 0);
    chk("rst_rsp_fields", {24'd0, rsp_result, rsp_fault, rsp_illegal, rsp_retries}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b);
      chk("vec_alu_a", {29'd0, s_a}, vt[i].ill ? 32'd0 : {29'd0, vt[i].a});
      chk("vec_alu_b", {29'd0, s_b}, vt[i].ill ? 32'd0 : {29'd0, vt[i].b});
      chk("vec_alu_c", {29'd0, s_c}, {29'd0, vt[i].c});
      chk("vec_alu_par", {31'd0, s_par}, {31'd0, vt[i].par});
      chk("vec_latency", s_lat, vt[i].lat);
      chk("vec_result", {28'd0, rsp_result}, {28'd0, vt[i].res});
      chk("vec_illegal", {31'd0, rsp_illegal}, {31'd0, vt[i].ill});
      chk("vec_fault", {31'd0, rsp_fault}, 0);
      chk("vec_retries", {30'd0, rsp_retries}, 0);
      chk("vec_err_cnt", {28'd0, err_cnt}, exp_err);
      ack();
    end

    // Transient error-pair fault on the first check only.
    xe_once = 1'b1;
    run_op(2'd0, 3'd3, 3'd2);
    xe_once = 1'b0;
    exp_err = 1;
    chk("retry1_latency", s_lat, 5);
    chk("retry1_result", {28'd0, rsp_result}, 32'h5);
    chk("retry1_retries", {30'd0, rsp_retries}, 1);
    chk("retry1_fault", {31'd0, rsp_fault}, 0);
    chk("retry1_err_cnt", {28'd0, err_cnt}, exp_err);
    ack();

    // Permanent channel disagreement: exhausts retries.
    y_bad = 1'b1;
    run_op(2'd0, 3'd1, 3'd1);
    exp_err = 4;
    chk("perm_latency", s_lat, 7);
    chk("perm_fault", {31'd0, rsp_fault}, 1);
    chk("perm_retries", {30'd0, rsp_retries}, 2);
    chk("perm_result", {28'd0, rsp_result}, 32'h2);
    chk("perm_err_cnt", {28'd0, err_cnt}, exp_err);
    ack();

    // Drive the 4-bit error counter into saturation and beyond.
    for (int k = 0; k < 5; k++) begin
      run_op(2'd1, 3'd6, 3'd2);
      exp_err = (exp_err + 3 > 15) ? 15 : exp_err + 3;
      chk("sat_fault", {31'd0, rsp_fault}, 1);
      chk("sat_err_cnt", {28'd0, err_cnt}, exp_err);
      ack();
    end
    y_bad = 1'b0;

    // Illegal op with the response stalled; a new request must wait.
    run_op(2'd3, 3'd7, 3'd7);
    chk("ill_latency", s_lat, 1);
    req_valid = 1'b1; req_op = 2'd0; req_a = 3'd1; req_b = 3'd2;
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("stall_rsp_fields", {24'd0, rsp_result, rsp_fault, rsp_illegal, rsp_retries}, 32'h4);
      chk("stall_alu_c", {29'd0, alu_c}, 0);
      chk("stall_req_ready", {31'd0, req_ready}, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stall_err_cnt", {28'd0, err_cnt}, exp_err);
    ack();

    // Reset in the middle of DRIVE: operation dropped, no response.
    req_op = 2'd1; req_a = 3'd6; req_b = 3'd1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_drive_alu_c", {29'd0, alu_c}, 32'h2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_alu_c", {29'd0, alu_c}, 0);
    chk("midrst_alu_par", {31'd0, alu_par}, 1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("midrst_err_cnt", {28'd0, err_cnt}, 0);
    chk("midrst_req_ready", {31'd0, req_ready}, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 0);
    end
    run_op(2'd0, 3'd2, 3'd3);
    chk("post_rst_latency", s_lat, 3);
    chk("post_rst_result", {28'd0, rsp_result}, 32'h5);
    chk("post_rst_err_cnt", {28'd0, err_cnt}, 0);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft_alu_sequencer.md
Name: ft_alu_sequencer

Overview:
- Sequences single operations through the combinational fault-tolerant 3-bit ALU (duplicated X/Y outputs, two-rail error pairs).
- Accepts valid/ready requests and drives the operand codeword, parity and one-hot control.
- Waits for settling, samples and checks both result channels, and retries on detected error.
- Returns the result, or a fault indication, on a valid/ready response channel. It is the only master of the ALU inputs.

Parameters:
- SETTLE_CYCLES, 1, cycles ALU inputs are held before sampling (1..15)
- MAX_RETRY, 2, re-executions allowed after a failed check (0..3)
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  0=ADD (A+B), 1=SUB_AB (A+(-B)), 2=SUB_BA ((-A)+B), 3=illegal
- req_a  in  3  operand A
- req_b  in  3  operand B
- alu_a  out  3  ALU A0..A2
- alu_b  out  3  ALU B0..B2
- alu_par  out  1  ALU PAR
- alu_c  out  3  ALU C0..C2: ADD=001, SUB_AB=010, SUB_BA=100
- alu_x  in  3  X2..X0
- alu_xc  in  1  XC
- alu_xe  in  2  {XE1,XE0}
- alu_y  in  3  Y2..Y0
- alu_yc  in  1  YC
- alu_ye  in  2  {YE1,YE0}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_result  out  4  {XC,X}
- rsp_fault  out  1  error persisted after MAX_RETRY retries
- rsp_illegal  out  1  op==3, ALU not driven
- rsp_retries  out  2  retries consumed
- err_cnt  out  ERR_CNT_W  failed checks since reset, saturating

Behaviour:
- Reset (sync, rst=1 at clk edge) puts the block in IDLE:
  - rsp_* = 0, err_cnt = 0, alu_a = alu_b = 0, alu_c = 000, alu_par = 1.
  - Valid from any state; an in-flight operation is discarded with no response.
- States: IDLE, DRIVE, CHECK, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, register op/a/b.
  - op<3: go to DRIVE with settle counter = SETTLE_CYCLES and retry count = 0.
  - op==3: go to RESP with rsp_illegal=1 and rsp_result=0; ALU stays at idle values.
- DRIVE:
  - alu_a/alu_b = registered operands.
  - alu_c = one-hot from op.
  - alu_par = ~(^a ^ ^b), which makes the codeword-check pair complementary.
  - Outputs are registered and stable for the whole operation, including retries.
  - The counter decrements each cycle. In the last DRIVE cycle, all alu_x/xc/xe/y/yc/ye are captured into registers. Next state is CHECK.
- CHECK (one cycle) evaluates the captured values. The check fails if any of these hold:
  - xe[1]==xe[0]
  - ye[1]==ye[0]
  - {xc,x} != {yc,y}
- On a failed check:
  - err_cnt increments and saturates at all-ones.
  - If retries < MAX_RETRY: retries+1, reload the counter, go to DRIVE.
  - Otherwise go to RESP with rsp_fault=1.
- On a passing check: go to RESP with rsp_fault=0.
- rsp_result = captured {xc,x}, also on fault.
- RESP:
  - rsp_valid = 1. All rsp_* fields are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE and clear rsp_valid. The ALU returns to idle values in the IDLE cycle.
- No back-to-back operations: a request arriving during RESP is accepted in the following IDLE cycle at the earliest.
- Latency: accept at edge k gives rsp_valid from cycle k+SETTLE_CYCLES+2. Each retry adds SETTLE_CYCLES+1 cycles. An illegal op responds at cycle k+1.
- Arithmetic is mod 8, with carry from the ALU. The sequencer computes no arithmetic itself.

Decomposition:
- Package ft_alu_pkg holds:
  - op codes (OP_ADD, OP_SUB_AB, OP_SUB_BA)
  - state enum
  - one-hot control constants
  - the two-rail "pair valid" function
- One natural sub-module, ft_alu_result_check: combinational fail detection from the captured X/Y/error fields.
- The FSM, counters and registers stay in the top.

Test Plan:
- SETTLE_CYCLES=1, golden ALU model. ADD a=3, b=2: alu_c=001, alu_par=~(0^1)=0; rsp_result=0101, fault=0, retries=0, rsp_valid 3 cycles after accept.
- SUB_AB a=3, b=2: alu_c=010, rsp_result=1001 (3+6). SUB_BA a=3, b=5: alu_c=100, rsp_result=1010 (5+5).
- Model forces alu_xe=11 on the first check only: err_cnt=1, rsp_retries=1, fault=0, correct result; latency +2 cycles.
- Model forces Y≠X permanently, MAX_RETRY=2: three checks, err_cnt=3, rsp_fault=1, rsp_retries=2.
- req_op=3: rsp_illegal=1 at the next cycle, alu_c stays 000. Holding rsp_ready=0 for 5 cycles keeps all rsp_* fields stable.
- Assert rst mid-DRIVE: next cycle IDLE, alu_c=000, alu_par=1, rsp_valid=0, err_cnt=0. Also drive err_cnt to saturation at all-ones and confirm it does not wrap.
